// File: rtl/l2_mem_arbiter.sv
// ----------------------------------------------------------------------------
// l2_mem_arbiter
//
// Shares the single core-side port of the L2 data cache between NUM_REQS L1
// data caches. Requests are arbitrated round-robin and pass through one
// registered output stage. The winning requester index is appended to the
// memory tag (index in the LSBs) so the L2 response can be steered back to
// its originator. The response path is purely combinational.
//
// Ports
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   in_req_*_i / _o         per-requester request side (flattened buses)
//   in_rsp_*_o / _i         per-requester response side (data/tag broadcast)
//   out_req_*_o / _i        request toward the L2 (tag widened by IDX_BITS)
//   out_rsp_*_i / _o        response from the L2
// ----------------------------------------------------------------------------
module l2_mem_arbiter #(
    parameter  int NUM_REQS      = 4,
    parameter  int ADDR_WIDTH    = 26,
    parameter  int DATA_WIDTH    = 512,
    parameter  int TAG_IN_WIDTH  = 8,
    localparam int IDX_BITS      = $clog2(NUM_REQS),
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_BITS,
    localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,

    input  logic [NUM_REQS-1:0]              in_req_valid_i,
    input  logic [NUM_REQS-1:0]              in_req_rw_i,
    input  logic [NUM_REQS*BE_WIDTH-1:0]     in_req_byteen_i,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   in_req_addr_i,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   in_req_data_i,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] in_req_tag_i,
    output logic [NUM_REQS-1:0]              in_req_ready_o,

    output logic [NUM_REQS-1:0]              in_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]            in_rsp_data_o,
    output logic [TAG_IN_WIDTH-1:0]          in_rsp_tag_o,
    input  logic [NUM_REQS-1:0]              in_rsp_ready_i,

    output logic                             out_req_valid_o,
    output logic                             out_req_rw_o,
    output logic [BE_WIDTH-1:0]              out_req_byteen_o,
    output logic [ADDR_WIDTH-1:0]            out_req_addr_o,
    output logic [DATA_WIDTH-1:0]            out_req_data_o,
    output logic [TAG_OUT_WIDTH-1:0]         out_req_tag_o,
    input  logic                             out_req_ready_i,

    input  logic                             out_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]            out_rsp_data_i,
    input  logic [TAG_OUT_WIDTH-1:0]         out_rsp_tag_i,
    output logic                             out_rsp_ready_o
);

    if (NUM_REQS < 2) begin : g_param_check
        $error("l2_mem_arbiter: NUM_REQS must be at least 2");
    end

    // Per-requester views of the flattened request buses.
    logic [BE_WIDTH-1:0]     req_be   [NUM_REQS];
    logic [ADDR_WIDTH-1:0]   req_addr [NUM_REQS];
    logic [DATA_WIDTH-1:0]   req_data [NUM_REQS];
    logic [TAG_IN_WIDTH-1:0] req_tag  [NUM_REQS];

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            req_be[i]   = in_req_byteen_i[i*BE_WIDTH +: BE_WIDTH];
            req_addr[i] = in_req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            req_data[i] = in_req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            req_tag[i]  = in_req_tag_i[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
        end
    end

    // State
    logic [IDX_BITS-1:0]      rr_q,        rr_d;
    logic                     out_valid_q, out_valid_d;
    logic                     rw_q,        rw_d;
    logic [BE_WIDTH-1:0]      be_q,        be_d;
    logic [ADDR_WIDTH-1:0]    addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]    data_q,      data_d;
    logic [TAG_OUT_WIDTH-1:0] tag_q,       tag_d;

    logic                     load;
    logic                     grant_found;
    logic [IDX_BITS-1:0]      grant_idx;

    // The output register may take a new request when empty or when its
    // current content is being accepted by the L2 in this same cycle.
    assign load = !out_valid_q || out_req_ready_i;

    // Round-robin search starting at rr_q, wrapping past NUM_REQS-1.
    always_comb begin
        int                  cand;
        logic [IDX_BITS-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end
            cand_idx = IDX_BITS'(cand);
            if (!grant_found && in_req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Ready goes only to the winner; a requester's own valid affects its
    // ready solely through the grant search above.
    always_comb begin
        in_req_ready_o = '0;
        if (grant_found && load) begin
            in_req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        rw_d        = rw_q;
        be_d        = be_q;
        addr_d      = addr_q;
        data_d      = data_q;
        tag_d       = tag_q;
        if (load) begin
            out_valid_d = grant_found;
            if (grant_found) begin
                rw_d   = in_req_rw_i[grant_idx];
                be_d   = req_be[grant_idx];
                addr_d = req_addr[grant_idx];
                data_d = req_data[grant_idx];
                tag_d  = {req_tag[grant_idx], grant_idx};
                rr_d   = (grant_idx == IDX_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            rw_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tag_q       <= '0;
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            rw_q        <= rw_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
        end
    end

    assign out_req_valid_o  = out_valid_q;
    assign out_req_rw_o     = rw_q;
    assign out_req_byteen_o = be_q;
    assign out_req_addr_o   = addr_q;
    assign out_req_data_o   = data_q;
    assign out_req_tag_o    = tag_q;

    // Response steering. An index with no matching requester (possible only
    // for non-power-of-two NUM_REQS) is accepted and dropped so the L2 port
    // never stalls on it.
    logic [IDX_BITS-1:0] rsp_idx;
    logic                rsp_hit;

    assign rsp_idx       = out_rsp_tag_i[IDX_BITS-1:0];
    assign in_rsp_tag_o  = out_rsp_tag_i[TAG_OUT_WIDTH-1:IDX_BITS];
    assign in_rsp_data_o = out_rsp_data_i;

    always_comb begin
        in_rsp_valid_o  = '0;
        out_rsp_ready_o = 1'b1;
        rsp_hit         = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rsp_idx == IDX_BITS'(i)) begin
                rsp_hit           = 1'b1;
                in_rsp_valid_o[i] = out_rsp_valid_i;
                out_rsp_ready_o   = in_rsp_ready_i[i];
            end
        end
    end

    a_rsp_idx_in_range : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(out_rsp_valid_i && !rsp_hit)
    ) else $error("l2_mem_arbiter: response tag index out of range, response dropped");

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_l2_mem_arbiter
//
// Directed bench for l2_mem_arbiter (NUM_REQS=4, DATA_WIDTH=32). A behavioural
// model tracks the pointer and the buffered request; a compare process checks
// every DUT output against it on each falling clock edge, and the directed
// sequence pins the model with hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_l2_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int TW  = 8;
    localparam int IB  = 2;
    localparam int TOW = TW + IB;
    localparam int BW  = DW / 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]    in_req_valid;
    logic [N-1:0]    in_req_rw;
    logic [N*BW-1:0] in_req_byteen;
    logic [N*AW-1:0] in_req_addr;
    logic [N*DW-1:0] in_req_data;
    logic [N*TW-1:0] in_req_tag;
    logic [N-1:0]    in_req_ready;
    logic [N-1:0]    in_rsp_valid;
    logic [DW-1:0]   in_rsp_data;
    logic [TW-1:0]   in_rsp_tag;
    logic [N-1:0]    in_rsp_ready;
    logic            out_req_valid;
    logic            out_req_rw;
    logic [BW-1:0]   out_req_byteen;
    logic [AW-1:0]   out_req_addr;
    logic [DW-1:0]   out_req_data;
    logic [TOW-1:0]  out_req_tag;
    logic            out_req_ready;
    logic            out_rsp_valid;
    logic [DW-1:0]   out_rsp_data;
    logic [TOW-1:0]  out_rsp_tag;
    logic            out_rsp_ready;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    l2_mem_arbiter #(
        .NUM_REQS    (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TAG_IN_WIDTH(TW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .in_req_valid_i  (in_req_valid),
        .in_req_rw_i     (in_req_rw),
        .in_req_byteen_i (in_req_byteen),
        .in_req_addr_i   (in_req_addr),
        .in_req_data_i   (in_req_data),
        .in_req_tag_i    (in_req_tag),
        .in_req_ready_o  (in_req_ready),
        .in_rsp_valid_o  (in_rsp_valid),
        .in_rsp_data_o   (in_rsp_data),
        .in_rsp_tag_o    (in_rsp_tag),
        .in_rsp_ready_i  (in_rsp_ready),
        .out_req_valid_o (out_req_valid),
        .out_req_rw_o    (out_req_rw),
        .out_req_byteen_o(out_req_byteen),
        .out_req_addr_o  (out_req_addr),
        .out_req_data_o  (out_req_data),
        .out_req_tag_o   (out_req_tag),
        .out_req_ready_i (out_req_ready),
        .out_rsp_valid_i (out_rsp_valid),
        .out_rsp_data_i  (out_rsp_data),
        .out_rsp_tag_i   (out_rsp_tag),
        .out_rsp_ready_o (out_rsp_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int              m_rr;
    logic            m_vld;
    logic            m_rw;
    logic [BW-1:0]   m_be;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [TOW-1:0]  m_tag;

    // Who would win right now: first valid requester at or after the pointer.
    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (in_req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rr <= 0; m_vld <= 1'b0; m_rw <= 1'b0;
            m_be <= '0; m_addr <= '0; m_data <= '0; m_tag <= '0;
        end else if (!m_vld || out_req_ready) begin
            int w;
            w = model_winner();
            if (w >= 0) begin
                m_vld  <= 1'b1;
                m_rw   <= in_req_rw[w];
                m_be   <= in_req_byteen[w*BW +: BW];
                m_addr <= in_req_addr[w*AW +: AW];
                m_data <= in_req_data[w*DW +: DW];
                m_tag  <= TOW'(in_req_tag[w*TW +: TW] * N + w);
                m_rr   <= (w + 1) % N;
            end else begin
                m_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int w;
            int ri;
            logic [N-1:0] exp_rdy;
            w = model_winner();
            exp_rdy = '0;
            if (w >= 0 && (!m_vld || out_req_ready)) exp_rdy = N'(1 << w);
            chk("mdl_in_req_ready", 64'(in_req_ready), 64'(exp_rdy));
            chk("mdl_out_valid", 64'(out_req_valid), 64'(m_vld));
            chk("mdl_out_rw", 64'(out_req_rw), 64'(m_rw));
            chk("mdl_out_be", 64'(out_req_byteen), 64'(m_be));
            chk("mdl_out_addr", 64'(out_req_addr), 64'(m_addr));
            chk("mdl_out_data", 64'(out_req_data), 64'(m_data));
            chk("mdl_out_tag", 64'(out_req_tag), 64'(m_tag));
            ri = int'(out_rsp_tag) % N;
            chk("mdl_rsp_valid", 64'(in_rsp_valid), 64'(out_rsp_valid ? (1 << ri) : 0));
            chk("mdl_rsp_tag", 64'(in_rsp_tag), 64'(int'(out_rsp_tag) / N));
            chk("mdl_rsp_data", 64'(in_rsp_data), 64'(out_rsp_data));
            chk("mdl_rsp_ready", 64'(out_rsp_ready), 64'(in_rsp_ready[ri]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int i, input logic [TW-1:0] tag, input logic [AW-1:0] addr);
        in_req_valid[i]            = 1'b1;
        in_req_rw[i]               = i[0];
        in_req_tag[i*TW +: TW]     = tag;
        in_req_addr[i*AW +: AW]    = addr;
        in_req_data[i*DW +: DW]    = 32'hD000_0000 | 32'(addr);
        in_req_byteen[i*BW +: BW]  = BW'(i + 1);
    endtask

    task automatic set_all();
        for (int i = 0; i < N; i++) set_req(i, TW'(8'h10 + i), AW'(26'h200 + i));
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [TOW-1:0] held_tag;
        int exp_order [5] = '{2, 3, 0, 1, 2};

        rst_n = 1'b0;
        in_req_valid = '0; in_req_rw = '0; in_req_byteen = '0;
        in_req_addr = '0; in_req_data = '0; in_req_tag = '0;
        in_rsp_ready = '0; out_req_ready = 1'b1;
        out_rsp_valid = 1'b0; out_rsp_data = 32'hCAFE_0001; out_rsp_tag = '0;

        // Reset state
        next_edge();
        next_edge();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_req_valid), 64'h0);
        chk("rst_out_tag", 64'(out_req_tag), 64'h0);
        chk("rst_out_addr", 64'(out_req_addr), 64'h0);
        next_edge();
        rst_n = 1'b1;

        // Single requester 2, no backpressure
        next_edge();
        set_req(2, 8'h5A, 26'h123);
        @(negedge clk);
        chk("single_ready", 64'(in_req_ready), 64'b0100);
        next_edge();
        in_req_valid = '0;
        @(negedge clk);
        chk("single_valid", 64'(out_req_valid), 64'h1);
        chk("single_tag", 64'(out_req_tag), 64'h16A);
        chk("single_addr", 64'(out_req_addr), 64'h123);

        // Transfer from req 1, then 3 idle cycles
        next_edge();
        set_req(1, 8'h11, 26'h42);
        @(negedge clk);
        chk("idle_req1_ready", 64'(in_req_ready), 64'b0010);
        next_edge();
        in_req_valid = '0;
        @(negedge clk);
        chk("idle_req1_tag", 64'(out_req_tag), 64'h45);
        for (int c = 0; c < 3; c++) begin
            next_edge();
            @(negedge clk);
            chk("idle_out_valid", 64'(out_req_valid), 64'h0);
        end

        // All valid: search resumes at index 2, then rotates
        next_edge();
        set_all();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fair_grant", 64'(in_req_ready), 64'(1 << exp_order[i]));
            next_edge();
        end

        // Backpressure with register full (holds req 2)
        out_req_ready = 1'b0;
        held_tag = out_req_tag;
        @(negedge clk);
        chk("bp_held_tag", 64'(out_req_tag), 64'h4A);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_ready_zero", 64'(in_req_ready), 64'h0);
            chk("bp_tag_stable", 64'(out_req_tag), 64'(held_tag));
            next_edge();
        end
        out_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 64'(in_req_ready), 64'b1000);
        next_edge();
        @(negedge clk);
        chk("bp_after_tag", 64'(out_req_tag), 64'h4F);
        chk("bp_next_grant", 64'(in_req_ready), 64'b0001);

        // Response routing
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {8'h33, 2'd3};
        out_rsp_data  = 32'h1234_5678;
        in_rsp_ready  = 4'b1000;
        #1;
        chk("rsp_valid", 64'(in_rsp_valid), 64'b1000);
        chk("rsp_tag", 64'(in_rsp_tag), 64'h33);
        chk("rsp_data", 64'(in_rsp_data), 64'h1234_5678);
        chk("rsp_ready", 64'(out_rsp_ready), 64'h1);
        in_rsp_ready = 4'b0111;
        #1;
        chk("rsp_ready_low", 64'(out_rsp_ready), 64'h0);
        next_edge();
        out_rsp_tag  = {8'hA5, 2'd1};
        in_rsp_ready = 4'b0010;
        @(negedge clk);
        chk("rsp_valid_idx1", 64'(in_rsp_valid), 64'b0010);
        out_rsp_valid = 1'b0;

        // Reset mid-operation: register full holding req 1, pointer at 2
        next_edge();
        in_req_valid = '0;
        next_edge();
        set_req(1, 8'h21, 26'h77);
        out_req_ready = 1'b0;
        next_edge();
        in_req_valid = '0;
        @(negedge clk);
        chk("mid_full", 64'(out_req_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_req_valid), 64'h0);
        chk("mid_rst_tag", 64'(out_req_tag), 64'h0);
        next_edge();
        rst_n = 1'b1;
        out_req_ready = 1'b1;
        set_all();
        @(negedge clk);
        chk("mid_first_grant", 64'(in_req_ready), 64'b0001);
        next_edge();
        in_req_valid = '0;
        next_edge();
        next_edge();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
